// File: rtl/grf_wb_port_if.sv
// Bundle between the write-back path / decode stage and the general register file.
// The master drives addresses, write triple and trace PC; the slave returns read data and trace state.
interface grf_wb_port_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [WIDTH-1:0]  RD1;
    logic [WIDTH-1:0]  RD2;
    logic              WE;
    logic [ADDR_W-1:0] A3;
    logic [WIDTH-1:0]  WD;
    logic [31:0]       PC;
    logic [CNT_W-1:0]  wr_cnt;
    logic [31:0]       last_pc;
    logic [ADDR_W-1:0] last_addr;
    logic [WIDTH-1:0]  last_data;
    logic              wr_valid;

    modport master (
        output A1, A2, WE, A3, WD, PC,
        input  RD1, RD2, wr_cnt, last_pc, last_addr, last_data, wr_valid
    );

    modport slave (
        input  A1, A2, WE, A3, WD, PC,
        output RD1, RD2, wr_cnt, last_pc, last_addr, last_data, wr_valid
    );
endinterface

// File: rtl/grf_wb_port.sv
// General register file fed by the write-back triple: two combinational read ports
// with optional write-to-read bypass, register 0 tied to zero, and a retired-write trace record.
module grf_wb_port #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 32
) (
    input logic          clk,
    input logic          reset,
    grf_wb_port_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [WIDTH-1:0]  r_regs [NREG];
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [31:0]       r_last_pc;
    logic [ADDR_W-1:0] r_last_addr;
    logic [WIDTH-1:0]  r_last_data;
    logic              r_wr_valid;
    logic              w_commit;
    logic [WIDTH-1:0]  w_rd1;
    logic [WIDTH-1:0]  w_rd2;

    // WE gates the address compare, so garbage on A3/WD with WE low can never commit.
    assign w_commit = bus.WE && (bus.A3 != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_cnt    <= '0;
            r_last_pc   <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
            r_wr_valid  <= 1'b0;
        end else if (w_commit) begin
            r_regs[bus.A3] <= bus.WD;
            r_wr_cnt       <= r_wr_cnt + CNT_W'(1);
            r_last_pc      <= bus.PC;
            r_last_addr    <= bus.A3;
            r_last_data    <= bus.WD;
            r_wr_valid     <= 1'b1;
        end else begin
            r_wr_valid <= 1'b0;
        end
    end

    always_comb begin
        w_rd1 = r_regs[bus.A1];
        if (bus.A1 == '0) begin
            w_rd1 = '0;
        end else if ((BYPASS != 0) && bus.WE && (bus.A3 == bus.A1)) begin
            w_rd1 = bus.WD;
        end
    end

    always_comb begin
        w_rd2 = r_regs[bus.A2];
        if (bus.A2 == '0) begin
            w_rd2 = '0;
        end else if ((BYPASS != 0) && bus.WE && (bus.A3 == bus.A2)) begin
            w_rd2 = bus.WD;
        end
    end

    assign bus.RD1       = w_rd1;
    assign bus.RD2       = w_rd2;
    assign bus.wr_cnt    = r_wr_cnt;
    assign bus.last_pc   = r_last_pc;
    assign bus.last_addr = r_last_addr;
    assign bus.last_data = r_last_data;
    assign bus.wr_valid  = r_wr_valid;
endmodule

// File: tb/tb_grf_wb_port.sv
// Directed bench for grf_wb_port: bypass, no-bypass and 4-bit-counter instances share one
// stimulus stream; expectations are queued when stimulus is applied and popped when checked.
module tb_grf_wb_port;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    grf_wb_port_if #(.WIDTH(32), .ADDR_W(5), .CNT_W(32)) ifb ();
    grf_wb_port_if #(.WIDTH(32), .ADDR_W(5), .CNT_W(32)) ifn ();
    grf_wb_port_if #(.WIDTH(32), .ADDR_W(5), .CNT_W(4))  ifc ();

    grf_wb_port #(.WIDTH(32), .ADDR_W(5), .BYPASS(1), .CNT_W(32)) dut_byp (
        .clk(clk), .reset(reset), .bus(ifb));
    grf_wb_port #(.WIDTH(32), .ADDR_W(5), .BYPASS(0), .CNT_W(32)) dut_nob (
        .clk(clk), .reset(reset), .bus(ifn));
    grf_wb_port #(.WIDTH(32), .ADDR_W(5), .BYPASS(1), .CNT_W(4)) dut_cnt4 (
        .clk(clk), .reset(reset), .bus(ifc));

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic expect_val(input string tag, input logic [63:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check_next(input logic [63:0] obs);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty observed=%h expected=<nothing queued>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2);
        ifb.WE = we; ifb.A3 = a3; ifb.WD = wd; ifb.PC = pc; ifb.A1 = a1; ifb.A2 = a2;
        ifn.WE = we; ifn.A3 = a3; ifn.WD = wd; ifn.PC = pc; ifn.A1 = a1; ifn.A2 = a2;
        ifc.WE = we; ifc.A3 = a3; ifc.WD = wd; ifc.PC = pc; ifc.A1 = a1; ifc.A2 = a2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_one(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        @(negedge clk);
        drive(1'b1, a3, wd, pc, 5'd0, 5'd0);
        step();
    endtask

    initial begin
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7);
        #2;
        expect_val("rst_wr_cnt", 64'h0);
        expect_val("rst_wr_valid", 64'h0);
        expect_val("rst_last_pc", 64'h0);
        expect_val("rst_last_addr", 64'h0);
        expect_val("rst_last_data", 64'h0);
        expect_val("rst_rd1", 64'h0);
        check_next(64'(ifb.wr_cnt));
        check_next(64'(ifb.wr_valid));
        check_next(64'(ifb.last_pc));
        check_next(64'(ifb.last_addr));
        check_next(64'(ifb.last_data));
        check_next(64'(ifb.RD1));
        @(negedge clk);
        reset = 1'b0;

        // Populate reg5 / reg7, then reset between edges
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h1234, 32'h100, 5'd5, 5'd7);
        expect_val("wr5_bypass_rd1", 64'h1234);
        #1 check_next(64'(ifb.RD1));
        step();
        @(negedge clk);
        drive(1'b1, 5'd7, 32'hFFFF0000, 32'h104, 5'd5, 5'd7);
        expect_val("wr7_valid", 64'h1);
        expect_val("wr7_last_addr", 64'h7);
        expect_val("wr7_last_data", 64'hFFFF0000);
        expect_val("wr7_last_pc", 64'h104);
        expect_val("wr7_cnt", 64'h2);
        step();
        check_next(64'(ifb.wr_valid));
        check_next(64'(ifb.last_addr));
        check_next(64'(ifb.last_data));
        check_next(64'(ifb.last_pc));
        check_next(64'(ifb.wr_cnt));
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7);
        expect_val("pre_rst_rd1", 64'h1234);
        expect_val("pre_rst_rd2", 64'hFFFF0000);
        #1;
        check_next(64'(ifn.RD1));
        check_next(64'(ifn.RD2));
        #1 reset = 1'b1;
        expect_val("midrst_rd1", 64'h0);
        expect_val("midrst_rd2", 64'h0);
        expect_val("midrst_cnt", 64'h0);
        expect_val("midrst_valid", 64'h0);
        expect_val("midrst_last_pc", 64'h0);
        expect_val("midrst_last_addr", 64'h0);
        expect_val("midrst_last_data", 64'h0);
        #1;
        check_next(64'(ifb.RD1));
        check_next(64'(ifb.RD2));
        check_next(64'(ifb.wr_cnt));
        check_next(64'(ifb.wr_valid));
        check_next(64'(ifb.last_pc));
        check_next(64'(ifb.last_addr));
        check_next(64'(ifb.last_data));

        // A write presented while reset is high is dropped
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h55, 32'h108, 5'd5, 5'd7);
        step();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7);
        expect_val("rst_edge_wr_rd1", 64'h0);
        expect_val("rst_edge_wr_cnt", 64'h0);
        #1;
        check_next(64'(ifn.RD1));
        check_next(64'(ifb.wr_cnt));

        // Register 0 writes for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 5'd0, 32'hDEADBEEF, 32'h200, 5'd0, 5'd0);
            expect_val("zero_rd1_pre", 64'h0);
            expect_val("zero_rd2_pre", 64'h0);
            #1;
            check_next(64'(ifb.RD1));
            check_next(64'(ifb.RD2));
            expect_val("zero_cnt", 64'h0);
            expect_val("zero_valid", 64'h0);
            expect_val("zero_rd1_post", 64'h0);
            step();
            check_next(64'(ifb.wr_cnt));
            check_next(64'(ifb.wr_valid));
            check_next(64'(ifb.RD1));
        end

        // Undefined A3/WD with WE low
        write_one(5'd3, 32'hA5, 32'h300);
        @(negedge clk);
        drive(1'b0, 5'bx, 32'bx, 32'h304, 5'd3, 5'd0);
        expect_val("xin_cnt", 64'h1);
        expect_val("xin_valid", 64'h0);
        expect_val("xin_rd1", 64'hA5);
        expect_val("xin_last_addr", 64'h3);
        expect_val("xin_last_data", 64'hA5);
        step();
        check_next(64'(ifb.wr_cnt));
        check_next(64'(ifb.wr_valid));
        check_next(64'(ifn.RD1));
        check_next(64'(ifb.last_addr));
        check_next(64'(ifb.last_data));

        // Bypass on vs off
        write_one(5'd9, 32'h11, 32'h400);
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h22, 32'h404, 5'd9, 5'd9);
        expect_val("byp_rd1_pre", 64'h22);
        expect_val("byp_rd2_pre", 64'h22);
        expect_val("nob_rd1_pre", 64'h11);
        expect_val("nob_rd2_pre", 64'h11);
        #1;
        check_next(64'(ifb.RD1));
        check_next(64'(ifb.RD2));
        check_next(64'(ifn.RD1));
        check_next(64'(ifn.RD2));
        expect_val("byp_rd1_post", 64'h22);
        expect_val("byp_rd2_post", 64'h22);
        expect_val("nob_rd1_post", 64'h22);
        expect_val("nob_rd2_post", 64'h22);
        step();
        check_next(64'(ifb.RD1));
        check_next(64'(ifb.RD2));
        check_next(64'(ifn.RD1));
        check_next(64'(ifn.RD2));
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h33, 32'h408, 5'd9, 5'd3);
        expect_val("indep_byp_rd1", 64'h33);
        expect_val("indep_byp_rd2", 64'hA5);
        expect_val("indep_nob_rd1", 64'h22);
        #1;
        check_next(64'(ifb.RD1));
        check_next(64'(ifb.RD2));
        check_next(64'(ifn.RD1));
        step();

        // Fresh reset before counter / trace sequence
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        write_one(5'd31, 32'h1, 32'h3000);
        write_one(5'd1, 32'h2, 32'h3004);
        expect_val("tr3_last_addr", 64'd31);
        expect_val("tr3_last_data", 64'h3);
        expect_val("tr3_last_pc", 64'h3008);
        expect_val("tr3_cnt", 64'h3);
        expect_val("tr3_valid", 64'h1);
        write_one(5'd31, 32'h3, 32'h3008);
        check_next(64'(ifb.last_addr));
        check_next(64'(ifb.last_data));
        check_next(64'(ifb.last_pc));
        check_next(64'(ifb.wr_cnt));
        check_next(64'(ifb.wr_valid));
        expect_val("tr4_last_addr", 64'd31);
        expect_val("tr4_last_data", 64'h3);
        expect_val("tr4_last_pc", 64'h3008);
        expect_val("tr4_cnt", 64'h3);
        expect_val("tr4_valid", 64'h0);
        write_one(5'd0, 32'h4, 32'h300C);
        check_next(64'(ifb.last_addr));
        check_next(64'(ifb.last_data));
        check_next(64'(ifb.last_pc));
        check_next(64'(ifb.wr_cnt));
        check_next(64'(ifb.wr_valid));
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd1);
        expect_val("tr_reg31", 64'h3);
        expect_val("tr_reg1", 64'h2);
        expect_val("tr_cnt4", 64'h3);
        #1;
        check_next(64'(ifn.RD1));
        check_next(64'(ifn.RD2));
        check_next(64'(ifc.wr_cnt));

        // Counter wrap on the 4-bit instance: 3 commits so far, 14 more
        for (int i = 0; i < 12; i++) begin
            write_one(5'd2, 32'(i + 16), 32'h5000 + 32'(4 * i));
        end
        expect_val("wrap_cnt_15", 64'hF);
        check_next(64'(ifc.wr_cnt));
        expect_val("wrap_cnt_16", 64'h0);
        expect_val("wrap_valid_16", 64'h1);
        write_one(5'd2, 32'h77, 32'h6000);
        check_next(64'(ifc.wr_cnt));
        check_next(64'(ifc.wr_valid));
        expect_val("wrap_cnt_17", 64'h1);
        expect_val("wide_cnt_17", 64'd17);
        expect_val("wrap_last_data", 64'h88);
        write_one(5'd2, 32'h88, 32'h6004);
        check_next(64'(ifc.wr_cnt));
        check_next(64'(ifb.wr_cnt));
        check_next(64'(ifc.last_data));

        if (sb.size() != 0) begin
            n_err++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/grf_wb_port.md
Name: grf_wb_port

Overview:
- General register file that consumes the write-back triple produced by the CPU write-back path: destination address, write data, and write enable.
- Serves two combinational read ports to the decode stage, with optional same-cycle write-to-read bypass.
- Register 0 is hard-wired to zero.
- Keeps a retired-write counter and a last-write record for bench/trace comparison.

Parameters:
- WIDTH, 32, data width of each register
- ADDR_W, 5, address width; register count = 2^ADDR_W
- BYPASS, 1, 1 = read port returns in-flight write data on address match; 0 = read returns stored value only
- CNT_W, 32, width of the retired-write counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- A1  input  ADDR_W  read address, port 1 (rs)
- A2  input  ADDR_W  read address, port 2 (rt)
- RD1  output  WIDTH  read data, port 1
- RD2  output  WIDTH  read data, port 2
- WE  input  1  write enable (RegWrite)
- A3  input  ADDR_W  write address (selected destination register)
- WD  input  WIDTH  write data (selected from ALU result / memory data / PC+4)
- PC  input  32  PC of the instruction writing back; trace only
- wr_cnt  output  CNT_W  count of committed writes to nonzero registers
- last_pc  output  32  PC of the most recent committed write
- last_addr  output  ADDR_W  address of the most recent committed write
- last_data  output  WIDTH  data of the most recent committed write
- wr_valid  output  1  pulses high for one cycle after each committed write

Behaviour:
- Reset: while reset=1, asynchronously clears:
  - all registers
  - wr_cnt, last_pc, last_addr, last_data, wr_valid
- Reset takes effect immediately regardless of clk. A write presented on the edge where reset is high is discarded.
- Write commit: on the rising clk edge with reset=0, WE=1 and A3!=0:
  - reg[A3] <= WD
  - wr_cnt <= wr_cnt+1; wraps to 0 after all-ones, with no saturation and no flag
  - last_pc <= PC, last_addr <= A3, last_data <= WD
  - wr_valid <= 1
- No commit when WE=0 or A3==0:
  - no register changes and wr_cnt holds
  - last_* hold
  - wr_valid <= 0
- Register 0: never written and always reads 0, including under bypass.
- Reads: combinational, zero latency. RDn = 0 if An==0.
  - Otherwise, if BYPASS=1 and WE=1 and A3==An, RDn = WD.
  - Otherwise RDn = reg[An].
- Both read ports may address the same register, or the write address, in the same cycle. Each port resolves independently by the rule above.
- With BYPASS=0, a read of A3 during the write cycle returns the old value. The new value appears after the edge.
- X/undefined inputs on A3 or WD with WE=0 must not corrupt state.
- Back-to-back writes to the same address: the last edge wins. wr_cnt increments on every committing edge.
- Writes need no handshake. The block is always ready, with one write per cycle maximum.

Test Plan:
- Reset mid-run:
  - Stimulus: write reg5=0x1234 and reg7=0xFFFF0000; raise reset between clk edges; read A1=5, A2=7.
  - Required: RD1=0 and RD2=0 immediately; wr_cnt=0, wr_valid=0, last_*=0.
- Zero register:
  - Stimulus: WE=1, A3=0, WD=0xDEADBEEF for 3 cycles; A1=0.
  - Required: RD1=0 throughout, including the bypass path; wr_cnt unchanged; wr_valid=0.
- Bypass on:
  - Stimulus: BYPASS=1; reg9=0x11; same cycle WE=1, A3=9, WD=0x22, A1=9, A2=9.
  - Required: RD1=RD2=0x22 before the edge and after the edge.
- Bypass off:
  - Stimulus: BYPASS=0, same stimulus as the bypass-on case.
  - Required: RD1=0x11 before the edge, 0x22 after the edge.
- Counter and trace:
  - Stimulus: 4 writes of 0x1/0x2/0x3/0x4 to registers 31/1/31/0, PC=0x3000, +4 per write, one per cycle.
  - Required:
    - wr_cnt=3 at the end.
    - After the third write: last_addr=31, last_data=0x3, last_pc=0x3008.
    - The fourth write (to reg0) leaves last_* unchanged and wr_valid low.
    - reg31=0x3.
- Counter wrap:
  - Stimulus: CNT_W=4; 17 committed writes.
  - Required: wr_cnt=1.
